aes_decryption: RTL

// - AES-128 inverse cipher (FIPS-197 InvCipher): the receive-side counterpart of the encryption pipeline.
// - Pulls 128-bit ciphertext blocks from the input FIFO and pushes 128-bit plaintext blocks to the output FIFO.
// - Round keys come from the shared key store; the top-level key schedule drives round_key_10 directly.
// - Datapath is a 3-stage recirculating ring; up to 3 blocks are in flight, interleaved.

---
 rtl/aes_decryption.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/aes_decryption.sv
// AES-128 inverse cipher on a 3-stage recirculating ring (up to 3 blocks interleaved); optional sticky overrun flag via AES_DEC_OVERRUN_FLAG_EN.
// Latency 30 edges from admission; is_full freezes the whole ring, admission only when slot_free.
module aes_decryption (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         read_fifo,
    input  logic [127:0] fifo_in,
    input  logic [127:0] round_key_10,
    input  logic [127:0] round_key_input,
    output logic [3:0]   round_key_addr,
    input  logic         is_full,
    output logic         slot_free,
    output logic [127:0] data_output,
    output logic         data_valid,
`ifdef AES_DEC_OVERRUN_FLAG_EN
    output logic         overrun,
`endif
    output logic         data_done
);

    localparam int NR = 10;

    typedef struct packed {
        logic         vld;
        logic [3:0]   rnd;
        logic [127:0] dat;
    } slot_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 2; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    // Byte k of a block sits at bits [127-8k -: 8]; state[r][c] is byte r+4c.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    slot_t s1, s2, s3, ring_in;
    logic  admit;

    // A finished block in S3 leaves this cycle, so its slot can take a new block.
    assign slot_free = ~is_full & (~s3.vld | (s3.rnd == 4'd0));
    assign admit     = read_fifo & slot_free;

    always_comb begin
        ring_in = '0;
        if (s3.vld && s3.rnd != 4'd0) begin
            ring_in.vld = 1'b1;
            ring_in.rnd = s3.rnd - 4'd1;
            ring_in.dat = s3.dat;
        end else if (admit) begin
            ring_in.vld = 1'b1;
            ring_in.rnd = 4'(NR - 1);
            ring_in.dat = fifo_in ^ round_key_10;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else if (!is_full) begin
            s1.vld <= ring_in.vld;
            s1.rnd <= ring_in.rnd;
            s1.dat <= inv_shift_sub(ring_in.dat);
            s2.vld <= s1.vld;
            s2.rnd <= s1.rnd;
            s2.dat <= s1.dat ^ round_key_input;
            s3.vld <= s2.vld;
            s3.rnd <= s2.rnd;
            s3.dat <= (s2.rnd != 4'd0) ? inv_mix(s2.dat) : s2.dat;
        end
    end

    assign round_key_addr = s1.rnd;
    assign data_valid     = s3.vld & (s3.rnd == 4'd0);
    assign data_output    = s3.dat;
    assign data_done      = data_valid & ~is_full;

`ifdef AES_DEC_OVERRUN_FLAG_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun <= 1'b0;
        end else if (read_fifo && !slot_free) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule
